// File: rtl/i2c_slave_responder.sv
// I2C target endpoint: START/STOP decode, 7-bit address match, register pointer,
// register writes and auto-incrementing burst reads against an external byte register file.
module i2c_slave_responder #(
   parameter logic [6:0] SLAVE_ADDR = 7'h76
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   input  logic [7:0] reg_rdata,
   output logic       busy
);

   // state    | meaning
   // IDLE     | bus free or after STOP
   // ADDR     | shifting in address + R/W byte
   // ADDR_ACK | acknowledging address, then branch on R/W
   // PTR      | shifting in register pointer byte
   // PTR_ACK  | acknowledging pointer byte
   // WR       | shifting in a write data byte
   // WR_ACK   | acknowledging a write data byte
   // RD       | shifting out a read data byte
   // RD_ACK   | sampling master ACK/NACK after a read byte
   // IGNORE   | not addressed or NACKed; wait for START/STOP
   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE
   } state_t;

   state_t     state;
   logic [2:0] scl_sync;
   logic [2:0] sda_sync;
   logic [7:0] shift;
   logic [2:0] bit_cnt;
   logic       ack_phase;
   logic       rw;

   // [0],[1] synchronizer, [2] history for edge detection; bus idles high
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync <= 3'b111;
         sda_sync <= 3'b111;
      end else begin
         scl_sync <= {scl_sync[1:0], scl_in};
         sda_sync <= {sda_sync[1:0], sda_in};
      end
   end

   logic scl_s, scl_h, sda_s, sda_h;
   logic scl_rise, scl_fall, start_det, stop_det;
   logic [7:0] rx_byte;

   assign scl_s     = scl_sync[1];
   assign scl_h     = scl_sync[2];
   assign sda_s     = sda_sync[1];
   assign sda_h     = sda_sync[2];
   assign scl_rise  = scl_s & ~scl_h;
   assign scl_fall  = ~scl_s & scl_h;
   assign start_det = scl_s & scl_h & ~sda_s & sda_h;
   assign stop_det  = scl_s & scl_h & sda_s & ~sda_h;
   assign rx_byte   = {shift[6:0], sda_s};

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sda_oe    <= 1'b0;
         reg_addr  <= 8'h00;
         reg_wdata <= 8'h00;
         reg_we    <= 1'b0;
         busy      <= 1'b0;
         shift     <= 8'h00;
         bit_cnt   <= 3'd0;
         ack_phase <= 1'b0;
         rw        <= 1'b0;
      end else begin
         reg_we <= 1'b0;
         // pointer advances the cycle after the write strobe so the strobe sees the old address
         if (reg_we)
            reg_addr <= reg_addr + 8'd1;

         if (stop_det) begin
            state     <= IDLE;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            bit_cnt   <= 3'd0;
            ack_phase <= 1'b0;
         end else if (start_det) begin
            state     <= ADDR;
            sda_oe    <= 1'b0;
            bit_cnt   <= 3'd0;
            ack_phase <= 1'b0;
         end else begin
            case (state)
               ADDR: begin
                  if (scl_rise) begin
                     shift   <= rx_byte;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        rw <= sda_s;
                        if (shift[6:0] == SLAVE_ADDR) begin
                           busy  <= 1'b1;
                           state <= ADDR_ACK;
                        end else begin
                           busy  <= 1'b0;
                           state <= IGNORE;
                        end
                     end
                  end
               end

               // first fall ends the 8th bit (drive ACK), second fall ends the 9th
               ADDR_ACK, PTR_ACK, WR_ACK: begin
                  if (scl_fall) begin
                     if (!ack_phase) begin
                        sda_oe    <= 1'b1;
                        ack_phase <= 1'b1;
                     end else begin
                        ack_phase <= 1'b0;
                        bit_cnt   <= 3'd0;
                        if (state == ADDR_ACK && rw) begin
                           shift  <= reg_rdata;
                           sda_oe <= ~reg_rdata[7];
                           state  <= RD;
                        end else begin
                           sda_oe <= 1'b0;
                           state  <= (state == ADDR_ACK) ? PTR : WR;
                        end
                     end
                  end
               end

               PTR: begin
                  if (scl_rise) begin
                     shift   <= rx_byte;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        reg_addr <= rx_byte;
                        state    <= PTR_ACK;
                     end
                  end
               end

               WR: begin
                  if (scl_rise) begin
                     shift   <= rx_byte;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        reg_wdata <= rx_byte;
                        reg_we    <= 1'b1;
                        state     <= WR_ACK;
                     end
                  end
               end

               RD: begin
                  if (scl_fall) begin
                     if (bit_cnt == 3'd7) begin
                        sda_oe  <= 1'b0;
                        bit_cnt <= 3'd0;
                        state   <= RD_ACK;
                     end else begin
                        shift   <= {shift[6:0], 1'b0};
                        sda_oe  <= ~shift[6];
                        bit_cnt <= bit_cnt + 3'd1;
                     end
                  end
               end

               // increment on the ACK rise so reg_rdata is settled by the following fall
               RD_ACK: begin
                  if (!ack_phase && scl_rise) begin
                     if (!sda_s) begin
                        reg_addr  <= reg_addr + 8'd1;
                        ack_phase <= 1'b1;
                     end else begin
                        state <= IGNORE;
                     end
                  end else if (ack_phase && scl_fall) begin
                     ack_phase <= 1'b0;
                     shift     <= reg_rdata;
                     sda_oe    <= ~reg_rdata[7];
                     bit_cnt   <= 3'd0;
                     state     <= RD;
                  end
               end

               default: begin
                  sda_oe <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bit-banged I2C master, behavioural register file,
// and a pointer/byte model computed from the protocol rules.
module tb_i2c_slave_responder;
   localparam int Q = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       scl_m, sda_m;
   logic       sda_bus;
   logic       sda_oe, reg_we, busy;
   logic [7:0] reg_addr, reg_wdata, reg_rdata;
   logic [7:0] mem [256];

   assign sda_bus   = sda_m & ~sda_oe;
   assign reg_rdata = mem[reg_addr];

   always #5 clk = ~clk;

   i2c_slave_responder #(.SLAVE_ADDR(7'h76)) dut (
      .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_bus), .sda_oe(sda_oe),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
      .reg_rdata(reg_rdata), .busy(busy)
   );

   int n_cmp = 0;
   int n_fail = 0;
   logic [15:0] wq[$];
   int oe_cnt = 0, busy_cnt = 0, multi_cnt = 0;
   logic prev_we = 1'b0;

   always @(negedge clk) begin
      if (reg_we === 1'b1) begin
         wq.push_back({reg_addr, reg_wdata});
         if (prev_we === 1'b1) multi_cnt++;
      end
      prev_we = reg_we;
      if (sda_oe === 1'b1) oe_cnt++;
      if (busy === 1'b1) busy_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b1; tick(Q);
   endtask

   task automatic wr_bit(input logic b);
      sda_m = b;    tick(Q);
      scl_m = 1'b1; tick(2*Q);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic rd_bit(output logic v);
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q);
      v = sda_bus;  tick(Q);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic wr_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) wr_bit(b[i]);
      rd_bit(ack);
   endtask

   task automatic rd_byte(input logic mack, output logic [7:0] b, output logic oe8);
      logic v;
      for (int i = 7; i >= 0; i--) begin
         rd_bit(v);
         b[i] = v;
      end
      oe8 = sda_oe;
      wr_bit(mack);
   endtask

   task automatic test_reset();
      rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
      tick(4);
      rst = 1'b0;
      tick(2);
      n_cmp++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
      n_cmp++; if (reg_we !== 1'b0) begin n_fail++; $display("FAIL reset_reg_we: got %b want 0", reg_we); end
      n_cmp++; if (reg_addr !== 8'h00) begin n_fail++; $display("FAIL reset_reg_addr: got %h want 00", reg_addr); end
      n_cmp++; if (reg_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_reg_wdata: got %h want 00", reg_wdata); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
   endtask

   task automatic test_write_single();
      logic a0, a1, a2;
      int base = wq.size();
      int mbase = multi_cnt;
      bus_start();
      wr_byte({7'h76, 1'b0}, a0);
      wr_byte(8'hF4, a1);
      wr_byte(8'h27, a2);
      n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL wr1_acks: got %b want 000", {a0, a1, a2}); end
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr1_busy_mid: got %b want 1", busy); end
      bus_stop();
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr1_busy_stop: got %b want 0", busy); end
      n_cmp++; if (reg_addr !== 8'hF5) begin n_fail++; $display("FAIL wr1_ptr_after: got %h want f5", reg_addr); end
      n_cmp++;
      if (wq.size() - base !== 1) begin
         n_fail++; $display("FAIL wr1_pulse_count: got %0d want 1", wq.size() - base);
      end else if (wq[base] !== 16'hF427) begin
         n_fail++; $display("FAIL wr1_write: got %h want f427", wq[base]);
      end
      n_cmp++; if (multi_cnt !== mbase) begin n_fail++; $display("FAIL wr1_pulse_width: got %0d extra want 0", multi_cnt - mbase); end
   endtask

   task automatic test_read_rs();
      logic a0, a1, a2, oe8;
      logic [7:0] b;
      int base = wq.size();
      bus_start();
      wr_byte({7'h76, 1'b0}, a0);
      wr_byte(8'hD0, a1);
      bus_start();
      wr_byte({7'h76, 1'b1}, a2);
      rd_byte(1'b1, b, oe8);
      n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL rd1_acks: got %b want 000", {a0, a1, a2}); end
      n_cmp++; if (b !== 8'h60) begin n_fail++; $display("FAIL rd1_byte: got %h want 60", b); end
      n_cmp++; if (oe8 !== 1'b0) begin n_fail++; $display("FAIL rd1_release: got %b want 0", oe8); end
      bus_stop();
      n_cmp++; if (wq.size() !== base) begin n_fail++; $display("FAIL rd1_no_we: got %0d writes want 0", wq.size() - base); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd1_busy: got %b want 0", busy); end
   endtask

   task automatic test_mismatch();
      logic a0, a1;
      int base = wq.size();
      int obase = oe_cnt;
      int bbase = busy_cnt;
      bus_start();
      wr_byte({7'h77, 1'b0}, a0);
      wr_byte(8'h55, a1);
      bus_stop();
      n_cmp++; if ({a0, a1} !== 2'b11) begin n_fail++; $display("FAIL nm_acks: got %b want 11", {a0, a1}); end
      n_cmp++; if (oe_cnt !== obase) begin n_fail++; $display("FAIL nm_oe: got %0d driven cycles want 0", oe_cnt - obase); end
      n_cmp++; if (wq.size() !== base) begin n_fail++; $display("FAIL nm_we: got %0d writes want 0", wq.size() - base); end
      n_cmp++; if (busy_cnt !== bbase) begin n_fail++; $display("FAIL nm_busy: got %0d busy cycles want 0", busy_cnt - bbase); end
   endtask

   task automatic test_burst_wrap();
      logic a0, a1, a2, oe8;
      logic [7:0] b;
      logic [7:0] p;
      bus_start();
      wr_byte({7'h76, 1'b0}, a0);
      wr_byte(8'hFE, a1);
      bus_start();
      wr_byte({7'h76, 1'b1}, a2);
      n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL wrap_acks: got %b want 000", {a0, a1, a2}); end
      for (int i = 0; i < 3; i++) begin
         p = 8'(8'hFE + i);
         rd_byte(i == 2, b, oe8);
         n_cmp++; if (b !== mem[p]) begin n_fail++; $display("FAIL wrap_byte%0d: got %h want %h", i, b, mem[p]); end
      end
      bus_stop();
      n_cmp++; if (reg_addr !== 8'h00) begin n_fail++; $display("FAIL wrap_ptr: got %h want 00", reg_addr); end
   endtask

   task automatic test_partial_write();
      logic a0, a1;
      int base = wq.size();
      bus_start();
      wr_byte({7'h76, 1'b0}, a0);
      wr_byte(8'h10, a1);
      for (int i = 0; i < 5; i++) wr_bit(1'($urandom));
      bus_stop();
      tick(2);
      n_cmp++; if (wq.size() !== base) begin n_fail++; $display("FAIL part_we: got %0d writes want 0", wq.size() - base); end
      n_cmp++; if (reg_addr !== 8'h10) begin n_fail++; $display("FAIL part_ptr: got %h want 10", reg_addr); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL part_busy: got %b want 0", busy); end
   endtask

   task automatic test_reset_mid_rd();
      logic a0, a1, a2;
      logic [7:0] d;
      int base;
      bus_start();
      wr_byte({7'h76, 1'b0}, a0);
      wr_byte(8'h40, a1);
      bus_start();
      wr_byte({7'h76, 1'b1}, a2);
      n_cmp++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rst_rd_driving: got %b want 1", sda_oe); end
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rst_rd_oe: got %b want 0", sda_oe); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_rd_busy: got %b want 0", busy); end
      n_cmp++; if (reg_addr !== 8'h00) begin n_fail++; $display("FAIL rst_rd_ptr: got %h want 00", reg_addr); end
      tick(2);
      rst = 1'b0;
      tick(2);
      base = wq.size();
      d = 8'($urandom);
      bus_start();
      wr_byte({7'h76, 1'b0}, a0);
      wr_byte(8'h20, a1);
      wr_byte(d, a2);
      bus_stop();
      n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL rst_after_acks: got %b want 000", {a0, a1, a2}); end
      n_cmp++;
      if (wq.size() - base !== 1) begin
         n_fail++; $display("FAIL rst_after_count: got %0d want 1", wq.size() - base);
      end else if (wq[base] !== {8'h20, d}) begin
         n_fail++; $display("FAIL rst_after_write: got %h want %h", wq[base], {8'h20, d});
      end
      n_cmp++; if (reg_addr !== 8'h21) begin n_fail++; $display("FAIL rst_after_ptr: got %h want 21", reg_addr); end
   endtask

   // Model: pointer set by the pointer byte, +1 per written byte and per master ACK on reads.
   task automatic test_random();
      logic [7:0] model_ptr = 8'h21;
      logic [7:0] p, b, exp_b;
      logic [7:0] d [3];
      logic [6:0] a;
      logic ack, oe8;
      int kind, n, base, obase;
      for (int it = 0; it < 10; it++) begin
         kind = $urandom_range(0, 2);
         p = 8'($urandom);
         n = $urandom_range(1, 3);
         base = wq.size();
         obase = oe_cnt;
         if (kind == 0) begin
            for (int i = 0; i < 3; i++) d[i] = 8'($urandom);
            bus_start();
            wr_byte({7'h76, 1'b0}, ack);
            n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_wr_addr_ack: got %b want 0", it, ack); end
            wr_byte(p, ack);
            n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_wr_ptr_ack: got %b want 0", it, ack); end
            for (int i = 0; i < n; i++) begin
               wr_byte(d[i], ack);
               n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_wr_data_ack%0d: got %b want 0", it, i, ack); end
            end
            bus_stop();
            n_cmp++;
            if (wq.size() - base !== n) begin
               n_fail++; $display("FAIL rnd%0d_wr_count: got %0d want %0d", it, wq.size() - base, n);
            end else begin
               for (int i = 0; i < n; i++) begin
                  n_cmp++;
                  if (wq[base+i] !== {8'(p + i), d[i]}) begin
                     n_fail++; $display("FAIL rnd%0d_wr_entry%0d: got %h want %h", it, i, wq[base+i], {8'(p + i), d[i]});
                  end
               end
            end
            model_ptr = 8'(p + n);
         end else if (kind == 1) begin
            bus_start();
            wr_byte({7'h76, 1'b0}, ack);
            wr_byte(p, ack);
            bus_start();
            wr_byte({7'h76, 1'b1}, ack);
            n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_rd_addr_ack: got %b want 0", it, ack); end
            for (int i = 0; i < n; i++) begin
               exp_b = mem[8'(p + i)];
               rd_byte(i == n - 1, b, oe8);
               n_cmp++; if (b !== exp_b) begin n_fail++; $display("FAIL rnd%0d_rd_byte%0d: got %h want %h", it, i, b, exp_b); end
            end
            bus_stop();
            n_cmp++; if (wq.size() !== base) begin n_fail++; $display("FAIL rnd%0d_rd_no_we: got %0d writes want 0", it, wq.size() - base); end
            model_ptr = 8'(p + n - 1);
         end else begin
            a = 7'($urandom);
            if (a == 7'h76) a = 7'h75;
            bus_start();
            wr_byte({a, 1'($urandom)}, ack);
            n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_nm_ack: got %b want 1", it, ack); end
            wr_byte(p, ack);
            bus_stop();
            n_cmp++; if (oe_cnt !== obase) begin n_fail++; $display("FAIL rnd%0d_nm_oe: got %0d driven cycles want 0", it, oe_cnt - obase); end
            n_cmp++; if (wq.size() !== base) begin n_fail++; $display("FAIL rnd%0d_nm_we: got %0d writes want 0", it, wq.size() - base); end
         end
         n_cmp++; if (reg_addr !== model_ptr) begin n_fail++; $display("FAIL rnd%0d_ptr: got %h want %h", it, reg_addr, model_ptr); end
         n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_busy: got %b want 0", it, busy); end
      end
   endtask

   initial begin
      rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[8'hD0] = 8'h60;
      mem[8'h40] = 8'h3C;
      test_reset();
      test_write_single();
      test_read_rs();
      test_mismatch();
      test_burst_wrap();
      test_partial_write();
      test_reset_mid_rd();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
